// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared types, widths and clamp limits for the PID sequencer
//
// Purpose: state encoding and datapath widths used by pid_sched and pid_mul.
// Ports:   none (package).
package pid_pkg;

    localparam int ERR_W   = 12;  // raw line error
    localparam int SAT_W   = 11;  // saturated error fed to the integrator
    localparam int DSAT_W  = 8;   // clamped derivative difference
    localparam int PID_W   = 16;  // summed command
    localparam int I_W     = 10;  // integrator term
    localparam int PROD_W  = 15;  // multiplier product
    localparam int DTERM_W = 12;  // registered D term

    // Limits are held at ERR_W so they compare directly against 12-bit values;
    // the low bits are the saturated codes themselves.
    localparam logic signed [ERR_W-1:0] ERR_MAX = 12'sd1023;
    localparam logic signed [ERR_W-1:0] ERR_MIN = -12'sd1024;
    localparam logic signed [ERR_W-1:0] D_MAX   = 12'sd127;
    localparam logic signed [ERR_W-1:0] D_MIN   = -12'sd128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SAT   = 3'd1,
        S_MUL_P = 3'd2,
        S_MUL_D = 3'd3,
        S_SUM   = 3'd4
    } pid_state_t;

endpackage

// File: rtl/pid_mul.sv
// rtl/pid_mul.sv - shared signed x unsigned multiplier for the P and D terms
//
// Purpose: the single multiplier instance time-shared between MUL_P and MUL_D.
// Ports:
//   a    : signed 11-bit multiplicand (saturated error or sign-extended d_sat)
//   b    : unsigned 4-bit gain
//   prod : signed 15-bit product, combinational
module pid_mul
    import pid_pkg::*;
(
    input  logic signed [SAT_W-1:0]  a,
    input  logic        [3:0]        b,
    output logic signed [PROD_W-1:0] prod
);

    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;

    // Zero-extend the gain so it stays positive in a signed multiply.
    assign a_ext = {{(PROD_W-SAT_W){a[SAT_W-1]}}, a};
    assign b_ext = {{(PROD_W-4){1'b0}}, b};
    assign prod  = a_ext * b_ext;

endmodule

// File: rtl/pid_sched.sv
// rtl/pid_sched.sv - sequencer for the PID datapath (saturate, P, D, sum)
//
// Purpose: takes one raw error per err_vld, saturates it, strobes it to the
// integrator, computes P and D on one shared multiplier and emits pid.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   go         : run enable; low aborts the sample and clears pid/err state
//   moving     : low forces the D term to zero
//   err        : raw signed line error, valid with err_vld
//   I_term     : integrator output, sampled in SUM
//   err_sat    : saturated error, err_vld_o strobes it in MUL_P
//   pid        : summed command, pid_vld strobes each new result
//   busy       : state is not IDLE
//   overrun    : sticky, set when a sample arrives while busy
module pid_sched
    import pid_pkg::*;
#(
    parameter logic [3:0] P_COEFF = 4'd12,
    parameter logic [3:0] D_COEFF = 4'd5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic                     moving,
    input  logic signed [ERR_W-1:0]  err,
    input  logic                     err_vld,
    input  logic signed [I_W-1:0]    I_term,
    output logic signed [SAT_W-1:0]  err_sat,
    output logic                     err_vld_o,
    output logic signed [PID_W-1:0]  pid,
    output logic                     pid_vld,
    output logic                     busy,
    output logic                     overrun
);

    pid_state_t                  state;
    logic signed [ERR_W-1:0]     err_raw;
    logic signed [SAT_W-1:0]     err_prev;
    logic signed [PROD_W-1:0]    p_term;
    logic signed [DTERM_W-1:0]   d_term;

    logic signed [SAT_W-1:0]     sat_nxt;
    logic signed [ERR_W-1:0]     d_diff;
    logic signed [DSAT_W-1:0]    d_sat;
    logic signed [SAT_W-1:0]     mul_a;
    logic        [3:0]           mul_b;
    logic signed [PROD_W-1:0]    mul_prod;

    assign busy = (state != S_IDLE);

    always_comb begin
        sat_nxt = err_raw[SAT_W-1:0];
        if (err_raw > ERR_MAX) begin
            sat_nxt = ERR_MAX[SAT_W-1:0];
        end else if (err_raw < ERR_MIN) begin
            sat_nxt = ERR_MIN[SAT_W-1:0];
        end
    end

    // Both operands span [-1024, 1023], so the 12-bit difference cannot wrap.
    assign d_diff = {err_sat[SAT_W-1], err_sat} - {err_prev[SAT_W-1], err_prev};

    always_comb begin
        d_sat = d_diff[DSAT_W-1:0];
        if (d_diff > D_MAX) begin
            d_sat = D_MAX[DSAT_W-1:0];
        end else if (d_diff < D_MIN) begin
            d_sat = D_MIN[DSAT_W-1:0];
        end
    end

    // Multiplier operands are steered by state: D in MUL_D, P otherwise.
    always_comb begin
        mul_a = err_sat;
        mul_b = P_COEFF;
        if (state == S_MUL_D) begin
            mul_a = {{(SAT_W-DSAT_W){d_sat[DSAT_W-1]}}, d_sat};
            mul_b = D_COEFF;
        end
    end

    pid_mul u_mul (
        .a    (mul_a),
        .b    (mul_b),
        .prod (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            err_raw   <= '0;
            err_sat   <= '0;
            err_prev  <= '0;
            err_vld_o <= 1'b0;
            p_term    <= '0;
            d_term    <= '0;
            pid       <= '0;
            pid_vld   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            err_vld_o <= 1'b0;
            pid_vld   <= 1'b0;
            if (!go) begin
                // Abort: drop any in-flight sample, keep overrun as-is.
                state    <= S_IDLE;
                pid      <= '0;
                err_prev <= '0;
                err_sat  <= '0;
            end else begin
                if (err_vld && (state != S_IDLE)) begin
                    overrun <= 1'b1;
                end
                case (state)
                    S_IDLE: begin
                        if (err_vld) begin
                            err_raw <= err;
                            state   <= S_SAT;
                        end
                    end
                    S_SAT: begin
                        err_sat   <= sat_nxt;
                        err_vld_o <= 1'b1;
                        state     <= S_MUL_P;
                    end
                    S_MUL_P: begin
                        p_term <= mul_prod;
                        state  <= S_MUL_D;
                    end
                    S_MUL_D: begin
                        // |d_sat * D_COEFF| <= 1920, so the low 12 bits hold it.
                        d_term   <= moving ? mul_prod[DTERM_W-1:0] : '0;
                        err_prev <= err_sat;
                        state    <= S_SUM;
                    end
                    S_SUM: begin
                        pid <= {{(PID_W-PROD_W){p_term[PROD_W-1]}}, p_term}
                             + {{(PID_W-I_W){I_term[I_W-1]}}, I_term}
                             + {{(PID_W-DTERM_W){d_term[DTERM_W-1]}}, d_term};
                        pid_vld <= 1'b1;
                        state   <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_sched.sv
// tb/tb_pid_sched.sv - self-checking bench for pid_sched
module tb_pid_sched;

    localparam int PC = 12;
    localparam int DC = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic               go;
    logic               moving;
    logic signed [11:0] err;
    logic               err_vld;
    logic signed [9:0]  i_term;
    logic signed [10:0] err_sat;
    logic               err_vld_o;
    logic signed [15:0] pid;
    logic               pid_vld;
    logic               busy;
    logic               overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int vld_cnt;

    always #5 clk = ~clk;

    pid_sched #(.P_COEFF(4'd12), .D_COEFF(4'd5)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .moving    (moving),
        .err       (err),
        .err_vld   (err_vld),
        .I_term    (i_term),
        .err_sat   (err_sat),
        .err_vld_o (err_vld_o),
        .pid       (pid),
        .pid_vld   (pid_vld),
        .busy      (busy),
        .overrun   (overrun)
    );

    typedef struct {
        int err;
        int iterm;
        bit mv;
        int exp_sat;
        int exp_pid;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        vld_cnt += int'(pid_vld);
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic send(input int e);
        err     = e[11:0];
        err_vld = 1'b1;
        step();
        err_vld = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[10];
        int   m_raw, m_sat, m_prev, m_p, m_d, m_pid, s, t, v;
        bit   active, m_ovr, exp_vo, exp_pv, exp_busy;

        // Expected values worked by hand from the clamp/gain rules, chained
        // through err_prev starting from the reset value 0.
        vec[0] = '{300,    0, 1'b1,   300,   4235};
        vec[1] = '{-2000, -4, 1'b1, -1024, -12932};
        vec[2] = '{300,    0, 1'b0,   300,   3600};
        vec[3] = '{2047, 511, 1'b1,  1023,  13422};
        vec[4] = '{1000,-512, 1'b1,  1000,  11373};
        vec[5] = '{-1024,  0, 1'b1, -1024, -12928};
        vec[6] = '{1023,   0, 1'b1,  1023,  12911};
        vec[7] = '{1024,   0, 1'b1,  1023,  12276};
        vec[8] = '{-1025,  0, 1'b1, -1024, -12928};
        vec[9] = '{-2048, -7, 1'b1, -1024, -12295};

        vld_cnt = 0;
        rst = 1'b1; go = 1'b1; moving = 1'b1; err = '0; err_vld = 1'b0; i_term = '0;
        step(); step();
        chk("rst err_sat",   int'(err_sat), 0);
        chk("rst err_vld_o", int'(err_vld_o), 0);
        chk("rst pid",       int'(pid), 0);
        chk("rst pid_vld",   int'(pid_vld), 0);
        chk("rst busy",      int'(busy), 0);
        chk("rst overrun",   int'(overrun), 0);
        rst = 1'b0;
        step();

        // Table vectors, one isolated sample each.
        for (int i = 0; i < 10; i++) begin
            i_term = vec[i].iterm[9:0];
            moving = vec[i].mv;
            send(vec[i].err);
            chk("vec busy", int'(busy), 1);
            step();
            chk("vec err_vld_o", int'(err_vld_o), 1);
            chk("vec err_sat",   int'(err_sat), vec[i].exp_sat);
            step(); step(); step();
            chk("vec pid_vld", int'(pid_vld), 1);
            chk("vec pid",     int'(pid), vec[i].exp_pid);
            chk("vec overrun", int'(overrun), 0);
            step();
            chk("vec pid_vld pulse", int'(pid_vld), 0);
        end

        // Overrun: second sample in MUL_P is dropped; one in the pid_vld cycle is taken.
        moving = 1'b1; i_term = '0;
        vld_cnt = 0;
        send(300);                  // edge s
        step();                     // s+1, MUL_P
        send(-500);                 // edge s+2, dropped
        chk("ovr overrun", int'(overrun), 1);
        step(); step();             // s+4
        chk("ovr pid first", int'(pid), 4235);
        chk("ovr pid_vld first", int'(pid_vld), 1);
        send(0);                    // accepted in pid_vld cycle
        chk("ovr accept busy", int'(busy), 1);
        step(); step(); step(); step();
        chk("ovr pid second", int'(pid), -640);
        chk("ovr pid_vld count", vld_cnt, 2);
        step();

        // Abort in MUL_D.
        vld_cnt = 0;
        send(100);                  // edge s
        step(); step();             // state MUL_D
        go = 1'b0;
        step();
        chk("abort busy",    int'(busy), 0);
        chk("abort pid",     int'(pid), 0);
        chk("abort err_sat", int'(err_sat), 0);
        chk("abort overrun", int'(overrun), 1);
        send(50);                   // ignored while go low
        chk("abort ign busy", int'(busy), 0);
        step(); step(); step(); step();
        chk("abort no pid_vld", vld_cnt, 0);
        go = 1'b1;
        step();
        send(100);
        step(); step(); step(); step();
        chk("abort resume pid_vld", int'(pid_vld), 1);
        chk("abort resume pid", int'(pid), 1700);
        step();

        // Reset while in SUM.
        send(300);
        step(); step(); step();
        chk("rmid busy before", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("rmid pid",       int'(pid), 0);
        chk("rmid pid_vld",   int'(pid_vld), 0);
        chk("rmid err_sat",   int'(err_sat), 0);
        chk("rmid err_vld_o", int'(err_vld_o), 0);
        chk("rmid busy",      int'(busy), 0);
        chk("rmid overrun",   int'(overrun), 0);
        rst = 1'b0;

        // Random traffic against a transaction-level model.
        m_sat = 0; m_prev = 0; m_pid = 0; m_p = 0; m_d = 0; m_raw = 0;
        m_ovr = 1'b0; active = 1'b0; s = 0;
        for (t = 0; t < 600; t++) begin
            v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 4095)) - 2048
                                            : int'($urandom_range(0, 2200)) - 1100;
            err     = v[11:0];
            err_vld = ($urandom_range(0, 99) < 35);
            moving  = ($urandom_range(0, 3) != 0);
            v       = int'($urandom_range(0, 1023)) - 512;
            i_term  = v[9:0];

            if (err_vld) begin
                if (active) m_ovr = 1'b1;
                else begin
                    active = 1'b1;
                    s      = t;
                    m_raw  = int'(err);
                end
            end
            exp_vo = 1'b0;
            exp_pv = 1'b0;
            if (active) begin
                if (t == s + 1) begin
                    m_sat  = clampi(m_raw, -1024, 1023);
                    exp_vo = 1'b1;
                end
                if (t == s + 2) m_p = m_sat * PC;
                if (t == s + 3) begin
                    m_d    = moving ? clampi(m_sat - m_prev, -128, 127) * DC : 0;
                    m_prev = m_sat;
                end
                if (t == s + 4) begin
                    m_pid  = m_p + int'(i_term) + m_d;
                    exp_pv = 1'b1;
                    active = 1'b0;
                end
            end
            exp_busy = active && (t <= s + 3);

            step();
            chk("rnd err_vld_o", int'(err_vld_o), int'(exp_vo));
            chk("rnd pid_vld",   int'(pid_vld),   int'(exp_pv));
            chk("rnd busy",      int'(busy),      int'(exp_busy));
            chk("rnd overrun",   int'(overrun),   int'(m_ovr));
            chk("rnd err_sat",   int'(err_sat),   m_sat);
            chk("rnd pid",       int'(pid),       m_pid);
        end
        err_vld = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
